mem_stream_reader: RTL and testbench
====================================

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of the memory read port.
REQ-002 Parameter DATA_W, default 64: memory read data width and stream width.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2): output buffer entries.
REQ-004 Parameter RD_LAT, default 1: fixed memory read latency in clk cycles.
REQ-005 clk  in  1: single clock; all logic is rising-edge.
REQ-006 reset_n  in  1: asynchronous assert, active-low reset.
REQ-007 start  in  1: one-cycle pulse; launches a transfer when idle.
REQ-008 abort  in  1: one-cycle pulse; terminates the active transfer.
REQ-009 base_addr  in  ADDR_W: first word address, sampled on accepted start.
REQ-010 word_count  in  ADDR_W+1: number of words, sampled on accepted start.
REQ-011 busy  out  1: high from accepted start until return to IDLE.
REQ-012 done  out  1: one-cycle pulse when the last word is accepted downstream or a zero-length transfer completes.
REQ-013 m_address  out  ADDR_W: memory word address.
REQ-014 m_chipselect  out  1: read issue strobe; one word requested per high cycle.
REQ-015 m_clken  out  1: memory clock enable, constant 1.
REQ-016 m_readdata  in  DATA_W: memory read data, valid exactly RD_LAT cycles after the issuing cycle.
REQ-017 out_data  out  DATA_W: stream data.
REQ-018 out_valid  out  1: stream data valid.
REQ-019 out_ready  in  1: downstream accept; transfer occurs when out_valid and out_ready are both high.
REQ-020 out_last  out  1: high with the final word of a transfer.

Function
REQ-021 States are IDLE, RUN, DRAIN; reset state is IDLE.
REQ-022 IDLE->RUN on start with word_count!=0; start with word_count==0 pulses done the next cycle and remains in IDLE.
REQ-023 start while busy is ignored.
REQ-024 In RUN, a read is issued (m_chipselect=1) only when in_flight + fifo_count < FIFO_DEPTH, so the FIFO never overflows and out_ready back-pressure never loses data.
REQ-025 Each issue increments m_address by 1 modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0) and decrements the remaining-issue count.
REQ-026 m_address holds its value when m_chipselect is low.
REQ-027 RUN->DRAIN in the cycle after the last read is issued; DRAIN->IDLE in the cycle after the last word is accepted downstream.
REQ-028 A returned word is captured into the FIFO exactly RD_LAT cycles after its issue; return order equals issue order.
REQ-029 The FIFO is first-word-fall-through: out_valid=1 whenever it is non-empty, and out_data is the head entry.
REQ-030 Simultaneous FIFO write and read when full or empty are legal; the count is unchanged by the pair.
REQ-031 out_last=1 only on the word whose downstream index equals word_count-1.
REQ-032 done pulses in the same cycle the last word is accepted; busy falls the following cycle.
REQ-033 With out_ready held high, sustained throughput is one word per cycle after an initial latency of RD_LAT+1 cycles from start to first out_valid.
REQ-034 On abort in RUN or DRAIN: issuing stops in the same cycle, the FIFO is flushed, in-flight returns are discarded, the block enters IDLE next cycle, and done is not pulsed.
REQ-035 abort in IDLE is ignored; abort and start in the same cycle while idle: start takes priority.

Reset
REQ-036 While reset_n=0: state=IDLE, busy=0, done=0, m_chipselect=0, m_address=0, m_clken=1, out_valid=0, out_last=0, out_data=0, FIFO empty, in-flight=0.
REQ-037 Reset assertion mid-transfer discards all data with no done pulse; the first start after reset release behaves as from power-up.

Verification
REQ-038 Memory model preloaded mem[i]=i; start base_addr=0x10, word_count=8, out_ready=1 -> out_data 0x10..0x17 on consecutive cycles, first out_valid 2 cycles after start, out_last and done on 0x17.
REQ-039 base_addr=0x3FFE, word_count=4 -> reads addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in that order.
REQ-040 word_count=16, out_ready toggled at random and held low for 10 cycles -> no lost or duplicated words, m_chipselect low while the FIFO plus in-flight count is 4, final order 0..15.
REQ-041 word_count=0 -> done 1 cycle later, m_chipselect never asserted, busy stays 0.
REQ-042 abort on the 3rd output word of a 32-word transfer -> out_valid low the next cycle, no done, busy low; a new start reads correctly from its own base_addr.
REQ-043 reset_n pulsed low mid-transfer -> all outputs at REQ-036 values immediately, with no clock edge required.

Source files
------------

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: issues sequential word reads to a fixed-latency memory
// port and streams the returned words out through a small first-word-fall-
// through buffer with valid/ready handshaking. Issue is throttled so that
// outstanding reads plus buffered words never exceed the buffer depth, which
// lets downstream back-pressure stall the stream without losing data.
module mem_stream_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remain;
    logic [ADDR_W:0]     r_wc;
    logic [ADDR_W:0]     r_out_idx;
    logic [RD_LAT-1:0]   r_pipe;
    logic                r_zero_done;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_zero_start;
    logic                w_abort;
    logic                w_issue;
    logic                w_capture;
    logic                w_fifo_nempty;
    logic                w_pop;
    logic                w_head_last;
    logic                w_last_pop;
    logic                w_room;
    logic [15:0]         w_in_flight;
    logic [15:0]         w_occupancy;

    // Handshake and issue qualifiers derived from current state and inputs.
    always_comb begin
        w_accept      = (r_state == ST_IDLE) && start && (word_count != (ADDR_W+1)'(0));
        w_zero_start  = (r_state == ST_IDLE) && start && (word_count == (ADDR_W+1)'(0));
        w_abort       = (r_state != ST_IDLE) && abort;
        w_occupancy   = w_in_flight + 16'(r_count);
        w_room        = (w_occupancy < 16'(FIFO_DEPTH));
        w_issue       = (r_state == ST_RUN) && (r_remain != (ADDR_W+1)'(0)) && w_room && !abort;
        w_capture     = r_pipe[RD_LAT-1] && !w_abort;
        w_fifo_nempty = (r_count != CNT_W'(0));
        w_pop         = w_fifo_nempty && out_ready;
        w_head_last   = w_fifo_nempty && (r_out_idx == (r_wc - (ADDR_W+1)'(1)));
        w_last_pop    = w_pop && w_head_last;
    end

    // Count of reads issued whose data has not yet returned.
    always_comb begin
        w_in_flight = 16'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + {15'd0, r_pipe[i]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; abort is only honoured while a transfer is active.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_issue && (r_remain == (ADDR_W+1)'(1))) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort || w_last_pop) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs and stream presentation of the buffer head.
    always_comb begin
        busy         = (r_state != ST_IDLE);
        m_chipselect = w_issue;
        m_clken      = 1'b1;
        out_valid    = w_fifo_nempty;
        out_last     = w_head_last;
        out_data     = w_fifo_nempty ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
        done         = r_zero_done || (w_last_pop && !abort && (r_state == ST_DRAIN));
    end

    assign m_address = r_addr;

    // Transfer bookkeeping: address, issues remaining, length and output index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= {ADDR_W{1'b0}};
            r_remain  <= {(ADDR_W+1){1'b0}};
            r_wc      <= {(ADDR_W+1){1'b0}};
            r_out_idx <= {(ADDR_W+1){1'b0}};
        end else if (w_accept) begin
            r_addr    <= base_addr;
            r_remain  <= word_count;
            r_wc      <= word_count;
            r_out_idx <= {(ADDR_W+1){1'b0}};
        end else begin
            if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - (ADDR_W+1)'(1);
            end
            if (w_pop) begin
                r_out_idx <= r_out_idx + (ADDR_W+1)'(1);
            end
        end
    end

    // Zero-length start completes with a done pulse one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_zero_start;
        end
    end

    // Read-latency tracker; abort drops all outstanding returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= {RD_LAT{1'b0}};
        end else if (w_abort) begin
            r_pipe <= {RD_LAT{1'b0}};
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Buffer pointers and occupancy; abort flushes the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (w_abort) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage; contents are only visible through out_data when valid.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= m_readdata;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: a word-addressed memory model
// with mem[i]=i and one-cycle read latency, and an expected-stream model that
// predicts each transfer as mem[(base+j) mod 2^14] with last on j=n-1.
module tb_mem_stream_reader;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int checks;
    int failures;

    mem_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .busy(busy), .done(done),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_clken(m_clken),
        .m_readdata(m_readdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data for an issue appears on the bus one cycle later.
    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= mem[m_address];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_cs"}, m_chipselect, 1'b0);
        chk64({tag, "_addr"}, 64'(m_address), 64'd0);
        chk1({tag, "_clken"}, m_clken, 1'b1);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk1({tag, "_last"}, out_last, 1'b0);
        chk64({tag, "_data"}, out_data, 64'd0);
    endtask

    // mode: 0 ready always high, 1 random ready, 2 random ready with a
    // 10-cycle low hold. abort_idx/restart_cyc/reset_cyc < 0 disable the event.
    task automatic run_transfer(input logic [ADDR_W-1:0] base, input int n, input int mode,
                                input int abort_idx, input int restart_cyc,
                                input int reset_cyc, input bit start_with_abort);
        logic [DATA_W-1:0] exp_q[$];
        logic [ADDR_W-1:0] exp_addr_q[$];
        logic [ADDR_W-1:0] iss_q[$];
        logic [ADDR_W-1:0] prev_addr;
        logic              prev_cs;
        int acc;
        int first_v;
        bit fin;
        prev_addr = '0;
        prev_cs   = 1'b0;
        for (int j = 0; j < n; j++) begin
            exp_addr_q.push_back(ADDR_W'(32'(base) + j));
            exp_q.push_back(mem[ADDR_W'(32'(base) + j)]);
        end
        base_addr  = base;
        word_count = (ADDR_W+1)'(n);
        start      = 1'b1;
        abort      = start_with_abort;
        #1;
        chk1("pre_start_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        acc = 0; first_v = -1; fin = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            abort = 1'b0;
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 2 && cyc >= 3 && cyc < 13) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            if (cyc == restart_cyc) begin
                start      = 1'b1;
                base_addr  = ~base;
                word_count = (ADDR_W+1)'(5);
            end
            if (cyc == reset_cyc) begin
                reset_n = 1'b0;
                #1;
                chk_reset_vals("mid_reset");
                @(posedge clk); #1;
                chk_reset_vals("held_reset");
                reset_n = 1'b1;
                return;
            end
            #1;
            if (out_valid && first_v < 0) first_v = cyc;
            if (abort_idx >= 0 && out_valid && acc == abort_idx) begin
                abort = 1'b1;
                #1;
                chk1("abort_cs", m_chipselect, 1'b0);
                chk1("abort_done", done, 1'b0);
                @(posedge clk); #1;
                abort = 1'b0;
                chk1("post_abort_valid", out_valid, 1'b0);
                chk1("post_abort_busy", busy, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk1("abort_quiet_valid", out_valid, 1'b0);
                    chk1("abort_quiet_done", done, 1'b0);
                    chk1("abort_quiet_cs", m_chipselect, 1'b0);
                end
                return;
            end
            chk1("busy_during", busy, 1'b1);
            if (cyc > 0 && !prev_cs) chk64("addr_hold", 64'(m_address), 64'(prev_addr));
            prev_cs   = m_chipselect;
            prev_addr = m_address;
            if (m_chipselect) begin
                chk1("issue_room", 1'((iss_q.size() - acc) < DEPTH), 1'b1);
                iss_q.push_back(m_address);
            end
            if (out_valid && out_ready) begin
                chk64("data", out_data, exp_q[acc]);
                chk1("last", out_last, 1'(acc == n - 1));
                chk1("done_on_last", done, 1'(acc == n - 1));
                if (mode == 0) chk64("consecutive", 64'(cyc), 64'(first_v + acc));
                acc++;
                if (acc == n) fin = 1'b1;
            end else begin
                chk1("no_done", done, 1'b0);
            end
        end
        chk1("transfer_completed", fin, 1'b1);
        if (fin) begin
            @(posedge clk); #1;
            chk1("busy_after", busy, 1'b0);
            chk1("done_after", done, 1'b0);
            chk64("issue_count", 64'(iss_q.size()), 64'(n));
            for (int j = 0; j < iss_q.size() && j < n; j++) begin
                chk64("issue_addr", 64'(iss_q[j]), 64'(exp_addr_q[j]));
            end
            if (mode == 0 && restart_cyc < 0) chk64("first_latency", 64'(first_v), 64'd2);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 64'(i);
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; word_count = '0;
        #2;
        chk_reset_vals("por");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("idle");

        // Basic streaming and address wrap.
        run_transfer(14'h0010, 8, 0, -1, -1, -1, 1'b0);
        run_transfer(14'h3FFE, 4, 0, -1, -1, -1, 1'b0);
        // Back-pressure with a long low hold.
        run_transfer(14'h0000, 16, 2, -1, -1, -1, 1'b0);

        // Zero-length start.
        base_addr = 14'h0123; word_count = '0; start = 1'b1;
        #1;
        chk1("zero_cs_start", m_chipselect, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        chk1("zero_done", done, 1'b1);
        chk1("zero_busy", busy, 1'b0);
        chk1("zero_cs", m_chipselect, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1("zero_done_once", done, 1'b0);
            chk1("zero_busy_after", busy, 1'b0);
            chk1("zero_cs_after", m_chipselect, 1'b0);
        end

        // Abort while idle has no effect.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk1("idle_abort_busy", busy, 1'b0);
        chk1("idle_abort_done", done, 1'b0);

        // Abort on the third word, then a clean transfer from a new base.
        run_transfer(14'h0040, 32, 0, 2, -1, -1, 1'b0);
        run_transfer(14'h0080, 6, 0, -1, -1, -1, 1'b0);
        // Start while busy is ignored.
        run_transfer(14'h0100, 12, 1, -1, 4, -1, 1'b0);
        // Reset mid-transfer, then a start with a simultaneous abort.
        run_transfer(14'h0200, 10, 1, -1, -1, 6, 1'b0);
        run_transfer(14'h0300, 5, 0, -1, -1, -1, 1'b1);

        // Randomized transfers.
        for (int t = 0; t < 6; t++) begin
            run_transfer(ADDR_W'($urandom), $urandom_range(1, 20), 1, -1, -1, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
